int_controller: RTL and testbench

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_int_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// int_controller: edge-triggered interrupt controller for a coprocessor.
// Rising edges on IRQ lines become pending requests. One enabled request is
// arbitrated (fixed priority or round-robin) and offered on INT. The offer is
// held until INT_ACK, a timeout, or a configuration write that disables it.
// A small register file (CTRL, EN, PENDING, STATUS) is reached over CFG_*.
module int_controller #(
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] IRQ,
    input  logic             INT_ACK,
    input  logic             ERET,
    input  logic             CFG_WE,
    input  logic             CFG_RE,
    input  logic [1:0]       CFG_ADDR,
    input  logic [31:0]      CFG_WDATA,
    output logic [31:0]      CFG_RDATA,
    output logic             INT,
    output logic [2:0]       IRQ_ID,
    output logic             BUSY,
    output logic [15:0]      DEBUG_INFO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_clear;
    logic [N_SRC-1:0] cfg_clear;
    logic [N_SRC-1:0] en;
    logic [N_SRC-1:0] en_next;
    logic [N_SRC-1:0] en_shifted;
    logic [N_SRC-1:0] arb_shifted;

    logic             gie;
    logic             gie_next;
    logic             rr;
    logic             rr_next;
    logic             flag_clear;
    logic             timeout_set;
    logic             timeout_flag;
    logic             timeout_flag_next;
    logic             int_q;

    logic [2:0]       rr_ptr;
    logic [2:0]       rr_ptr_next;
    logic [2:0]       irq_id;
    logic [2:0]       irq_id_next;
    logic [2:0]       winner;
    logic             win_found;
    int               arb_idx;

    logic [7:0]       count;
    logic [7:0]       count_next;

    logic [31:0]      read_value;
    logic [31:0]      rdata_q;
    logic [7:0]       pend_pad;
    logic             unused_bits;

    // A request is a 0->1 transition between the previous and current sample.
    assign rise     = IRQ & ~irq_q;
    assign eligible = pending & en;

    // Decode configuration writes into the values the control registers
    // will hold after this edge, plus the write-one-to-clear strobes.
    always_comb begin
        gie_next   = gie;
        rr_next    = rr;
        en_next    = en;
        cfg_clear  = '0;
        flag_clear = 1'b0;
        if (CFG_WE) begin
            case (CFG_ADDR)
                2'd0: begin
                    gie_next = CFG_WDATA[0];
                    rr_next  = CFG_WDATA[1];
                end
                2'd1:    en_next    = CFG_WDATA[N_SRC-1:0];
                2'd2:    cfg_clear  = CFG_WDATA[N_SRC-1:0];
                default: flag_clear = 1'b1;
            endcase
        end
    end

    // Pick the winning source: lowest index, or the first one at or above
    // rr_ptr (wrapping) when round-robin is selected.
    always_comb begin
        winner      = '0;
        win_found   = 1'b0;
        arb_idx     = 0;
        arb_shifted = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (rr) begin
                arb_idx = (int'(rr_ptr) + k) % N_SRC;
            end else begin
                arb_idx = k;
            end
            arb_shifted = eligible >> arb_idx;
            if (!win_found && arb_shifted[0]) begin
                winner    = 3'(arb_idx);
                win_found = 1'b1;
            end
        end
    end

    // Next-state logic for the grant handshake. Within REQ an acknowledge
    // beats a withdrawal, which in turn beats a timeout.
    always_comb begin
        state_next  = state;
        irq_id_next = irq_id;
        count_next  = count;
        rr_ptr_next = rr_ptr;
        ack_clear   = '0;
        timeout_set = 1'b0;
        en_shifted  = en_next >> irq_id;
        case (state)
            IDLE: begin
                if (gie && win_found) begin
                    irq_id_next = winner;
                    count_next  = '0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    ack_clear  = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id;
                    state_next = SERV;
                end else if (!gie_next || !en_shifted[0]) begin
                    state_next = IDLE;
                end else if (count == 8'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            SERV: begin
                if (ERET) begin
                    state_next  = IDLE;
                    rr_ptr_next = (irq_id == 3'(N_SRC - 1)) ? 3'd0 : irq_id + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new edge always wins over a same-cycle clear, so nothing is lost.
    assign pending_next      = (pending & ~(ack_clear | cfg_clear)) | rise;
    assign timeout_flag_next = timeout_set | (timeout_flag & ~flag_clear);

    // Register read multiplexer; it sees the values before any same-cycle write.
    always_comb begin
        read_value = '0;
        case (CFG_ADDR)
            2'd0:    read_value = {30'd0, rr, gie};
            2'd1:    read_value = 32'(en);
            2'd2:    read_value = 32'(pending);
            default: read_value = {23'd0, timeout_flag, 2'b00, state, 1'b0, irq_id};
        endcase
    end

    // Configuration registers: GIE, RR and the per-source enables.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gie <= 1'b1;
            rr  <= 1'b0;
            en  <= '1;
        end else begin
            gie <= gie_next;
            rr  <= rr_next;
            en  <= en_next;
        end
    end

    // Controller state: edge detector, pending set, FSM, counter and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            irq_q        <= '0;
            pending      <= '0;
            irq_id       <= '0;
            rr_ptr       <= '0;
            count        <= '0;
            timeout_flag <= 1'b0;
            int_q        <= 1'b0;
        end else begin
            state        <= state_next;
            irq_q        <= IRQ;
            pending      <= pending_next;
            irq_id       <= irq_id_next;
            rr_ptr       <= rr_ptr_next;
            count        <= count_next;
            timeout_flag <= timeout_flag_next;
            int_q        <= (state_next == REQ);
        end
    end

    // Read data is presented for exactly one cycle after a read strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (CFG_RE) begin
            rdata_q <= read_value;
        end else begin
            rdata_q <= '0;
        end
    end

    assign pend_pad    = 8'(pending);
    assign unused_bits = ^{CFG_WDATA[31:N_SRC], pend_pad[7:6]};

    assign CFG_RDATA  = rdata_q;
    assign INT        = int_q;
    assign IRQ_ID     = irq_id;
    assign BUSY       = (state == REQ) || (state == SERV);
    assign DEBUG_INFO = {timeout_flag, 1'b0, state, irq_id, rr_ptr, pend_pad[5:0]};

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller. Stimulus pushes the expected grant ID
// or read value into a queue; a monitor pops and compares each time INT rises
// or read data comes back. A few timing-sensitive points are checked inline.
module tb_int_controller;

    localparam int N_SRC   = 4;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             reset;
    logic [N_SRC-1:0] IRQ;
    logic             INT_ACK;
    logic             ERET;
    logic             CFG_WE;
    logic             CFG_RE;
    logic [1:0]       CFG_ADDR;
    logic [31:0]      CFG_WDATA;
    logic [31:0]      CFG_RDATA;
    logic             INT;
    logic [2:0]       IRQ_ID;
    logic             BUSY;
    logic [15:0]      DEBUG_INFO;

    int               vectors    = 0;
    int               miscompares = 0;
    logic [2:0]       grant_q[$];
    logic [31:0]      read_q[$];

    int_controller #(.N_SRC(N_SRC), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .IRQ        (IRQ),
        .INT_ACK    (INT_ACK),
        .ERET       (ERET),
        .CFG_WE     (CFG_WE),
        .CFG_RE     (CFG_RE),
        .CFG_ADDR   (CFG_ADDR),
        .CFG_WDATA  (CFG_WDATA),
        .CFG_RDATA  (CFG_RDATA),
        .INT        (INT),
        .IRQ_ID     (IRQ_ID),
        .BUSY       (BUSY),
        .DEBUG_INFO (DEBUG_INFO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string detail);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        CFG_WE    = 1'b1;
        CFG_ADDR  = addr;
        CFG_WDATA = data;
        step();
        CFG_WE    = 1'b0;
        CFG_WDATA = '0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, input logic [31:0] expected);
        CFG_RE   = 1'b1;
        CFG_ADDR = addr;
        read_q.push_back(expected);
        step();
        CFG_RE   = 1'b0;
    endtask

    task automatic serve();
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        ERET    = 1'b1;
        step();
        ERET    = 1'b0;
    endtask

    // Monitor: compares read data and every new grant against the queues.
    initial begin
        logic re_s;
        logic int_prev;
        int_prev = 1'b0;
        forever begin
            @(posedge clk);
            re_s = CFG_RE;
            #1;
            if (re_s) begin
                if (read_q.size() == 0) begin
                    report_fail("cfg_rdata", $sformatf("got %0h, expected no read data", CFG_RDATA));
                end else begin
                    check_output("cfg_rdata", CFG_RDATA, read_q.pop_front());
                end
            end else begin
                check_output("rdata_idle", CFG_RDATA, 32'h0);
            end
            if (INT && !int_prev) begin
                if (grant_q.size() == 0) begin
                    report_fail("grant", $sformatf("got unexpected grant id %0d, expected none", IRQ_ID));
                end else begin
                    check_output("grant_id", 32'(IRQ_ID), 32'(grant_q.pop_front()));
                end
            end
            int_prev = INT;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        IRQ       = '0;
        INT_ACK   = 1'b0;
        ERET      = 1'b0;
        CFG_WE    = 1'b0;
        CFG_RE    = 1'b0;
        CFG_ADDR  = '0;
        CFG_WDATA = '0;
        repeat (3) step();
        check_output("rst_int", 32'(INT), 0);
        check_output("rst_busy", 32'(BUSY), 0);
        check_output("rst_irq_id", 32'(IRQ_ID), 0);
        check_output("rst_debug", 32'(DEBUG_INFO), 0);
        reset = 1'b1;
        step();

        // Register reset values, and handshake pulses ignored while idle
        cfg_read(2'd0, 32'h1);
        cfg_read(2'd1, 32'hF);
        cfg_read(2'd2, 32'h0);
        cfg_read(2'd3, 32'h0);
        INT_ACK = 1'b1;
        ERET    = 1'b1;
        step();
        INT_ACK = 1'b0;
        ERET    = 1'b0;
        check_output("idle_ignores_ack", 32'(DEBUG_INFO[13:12]), 0);
        check_output("idle_busy", 32'(BUSY), 0);

        // Simultaneous write and read returns the old value
        CFG_WE    = 1'b1;
        CFG_RE    = 1'b1;
        CFG_ADDR  = 2'd1;
        CFG_WDATA = 32'h5;
        read_q.push_back(32'hF);
        step();
        CFG_WE    = 1'b0;
        CFG_RE    = 1'b0;
        cfg_read(2'd1, 32'h5);
        cfg_write(2'd1, 32'hF);

        // Pending register read and write-one-to-clear with GIE off
        cfg_write(2'd0, 32'h0);
        IRQ = 4'b1000;
        step();
        step();
        check_output("gie_off_no_int", 32'(INT), 0);
        cfg_read(2'd2, 32'h8);
        cfg_write(2'd2, 32'h8);
        cfg_read(2'd2, 32'h0);
        cfg_write(2'd0, 32'h1);
        IRQ = '0;
        step();
        step();
        check_output("cleared_no_int", 32'(INT), 0);

        // Single source: latency, acknowledge, return
        IRQ = 4'b0001;
        grant_q.push_back(3'd0);
        step();
        check_output("pend_after_edge", 32'(DEBUG_INFO[5:0]), 32'h1);
        check_output("int_not_yet", 32'(INT), 0);
        step();
        check_output("int_asserted", 32'(INT), 1);
        check_output("busy_in_req", 32'(BUSY), 1);
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        check_output("state_serv", 32'(DEBUG_INFO[13:12]), 2);
        check_output("pend_cleared", 32'(DEBUG_INFO[5:0]), 0);
        check_output("int_off_serv", 32'(INT), 0);
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        check_output("serv_ignores_ack", 32'(DEBUG_INFO[13:12]), 2);
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        check_output("idle_after_eret", 32'(BUSY), 0);
        check_output("rr_ptr_1", 32'(DEBUG_INFO[8:6]), 1);
        IRQ = '0;
        step();

        // Fixed priority: sources 1 and 3 together, 1 first then 3
        IRQ = 4'b1010;
        grant_q.push_back(3'd1);
        grant_q.push_back(3'd3);
        step();
        step();
        serve();
        step();
        serve();
        check_output("rr_ptr_wrap", 32'(DEBUG_INFO[8:6]), 0);
        IRQ = '0;
        step();

        // Round-robin: bring rr_ptr to 2, then pending 0011 wraps to 0
        cfg_write(2'd0, 32'h3);
        cfg_read(2'd0, 32'h3);
        IRQ = 4'b0010;
        grant_q.push_back(3'd1);
        step();
        step();
        serve();
        check_output("rr_ptr_2", 32'(DEBUG_INFO[8:6]), 2);
        IRQ = '0;
        step();
        IRQ = 4'b0011;
        grant_q.push_back(3'd0);
        grant_q.push_back(3'd1);
        step();
        step();
        serve();
        step();
        serve();
        IRQ = '0;
        step();
        // rr_ptr=2, pending 0101: round-robin picks 2 before 0
        IRQ = 4'b0101;
        grant_q.push_back(3'd2);
        grant_q.push_back(3'd0);
        step();
        step();
        serve();
        step();
        serve();
        check_output("rr_ptr_after_0", 32'(DEBUG_INFO[8:6]), 1);
        IRQ = '0;
        step();
        cfg_write(2'd0, 32'h1);

        // Timeout: INT held 16 cycles, drops for one, then re-asserts
        IRQ = 4'b0100;
        grant_q.push_back(3'd2);
        grant_q.push_back(3'd2);
        step();
        step();
        check_output("to_int_first", 32'(INT), 1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            check_output("to_int_held", 32'(INT), 1);
        end
        step();
        check_output("to_int_drop", 32'(INT), 0);
        check_output("to_flag", 32'(DEBUG_INFO[15]), 1);
        check_output("to_pend_kept", 32'(DEBUG_INFO[5:0]), 32'h4);
        cfg_read(2'd3, 32'h102);
        check_output("to_int_again", 32'(INT), 1);
        cfg_write(2'd3, 32'h0);
        cfg_read(2'd3, 32'h012);
        serve();
        IRQ = '0;
        step();

        // Withdraw: disabling the granted source drops INT without a flag
        IRQ = 4'b0100;
        grant_q.push_back(3'd2);
        step();
        step();
        cfg_write(2'd1, 32'hB);
        check_output("wd_int", 32'(INT), 0);
        check_output("wd_state", 32'(DEBUG_INFO[13:12]), 0);
        check_output("wd_flag", 32'(DEBUG_INFO[15]), 0);
        step();
        check_output("wd_stays_off", 32'(INT), 0);
        grant_q.push_back(3'd2);
        cfg_write(2'd1, 32'hF);
        step();
        // Acknowledge in the same cycle as a GIE clear still goes to SERV
        INT_ACK   = 1'b1;
        CFG_WE    = 1'b1;
        CFG_ADDR  = 2'd0;
        CFG_WDATA = 32'h0;
        step();
        INT_ACK   = 1'b0;
        CFG_WE    = 1'b0;
        check_output("ack_beats_wd", 32'(DEBUG_INFO[13:12]), 2);
        ERET = 1'b1;
        step();
        ERET = 1'b0;
        cfg_write(2'd0, 32'h1);
        IRQ = '0;
        step();

        // New edge in the acknowledge cycle keeps pending, then reset in SERV
        cfg_write(2'd0, 32'h3);
        cfg_write(2'd1, 32'h7);
        IRQ = 4'b0010;
        grant_q.push_back(3'd1);
        step();
        IRQ = '0;
        step();
        INT_ACK = 1'b1;
        IRQ     = 4'b0010;
        step();
        INT_ACK = 1'b0;
        check_output("edge_in_ack_state", 32'(DEBUG_INFO[13:12]), 2);
        check_output("edge_in_ack_pend", 32'(DEBUG_INFO[5:0]), 32'h2);
        reset = 1'b0;
        step();
        check_output("mid_rst_int", 32'(INT), 0);
        check_output("mid_rst_busy", 32'(BUSY), 0);
        check_output("mid_rst_irq_id", 32'(IRQ_ID), 0);
        check_output("mid_rst_debug", 32'(DEBUG_INFO), 0);
        grant_q.push_back(3'd1);
        reset = 1'b1;
        step();
        step();
        check_output("held_irq_regrant", 32'(INT), 1);
        serve();
        IRQ = '0;
        step();
        cfg_read(2'd0, 32'h1);
        cfg_read(2'd1, 32'hF);

        repeat (3) step();
        while (grant_q.size() > 0) begin
            report_fail("grant_missing", $sformatf("got no grant, expected id %0d", grant_q.pop_front()));
        end
        while (read_q.size() > 0) begin
            report_fail("read_missing", $sformatf("got no read data, expected %0h", read_q.pop_front()));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
